// File: rtl/smc_mem_resp_lite18_pkg.sv
// smc_resp_pkg_lite18
//   Shared definitions for the SMC memory responder slice.
//   - default address/data widths
//   - FSM state encoding
//   - protocol-violation codes reported on viol_code18
package smc_resp_pkg_lite18;

  localparam int SMC_ADDR_W_DEF = 4;
  localparam int SMC_DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR      = 3'd4
  } smcState_e;

  localparam logic [1:0] VIOL_NONE     = 2'd0;
  localparam logic [1:0] VIOL_RW_BOTH  = 2'd1;
  localparam logic [1:0] VIOL_RD_ABORT = 2'd2;
  localparam logic [1:0] VIOL_WR_ADDR  = 2'd3;

endpackage

// File: rtl/smc_mem_resp_lite18_mem.sv
// smc_resp_mem_lite18
//   Byte-writable register array with asynchronous read and reset clear.
//   Ports:
//     sys_clk18      - clock, rising edge
//     n_sys_reset18  - async active-low reset, clears every word
//     wrEn_i         - commit a write this cycle
//     wrAddr_i       - word address of the write
//     wrData_i       - write data
//     wrBeN_i        - active-low byte lane enables for the write
//     rdAddr_i       - word address for the combinational read port
//     rdData_o       - word at rdAddr_i
module smc_resp_mem_lite18 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                  sys_clk18,
  input  logic                  n_sys_reset18,
  input  logic                  wrEn_i,
  input  logic [ADDR_W-1:0]     wrAddr_i,
  input  logic [DATA_W-1:0]     wrData_i,
  input  logic [DATA_W/8-1:0]   wrBeN_i,
  input  logic [ADDR_W-1:0]     rdAddr_i,
  output logic [DATA_W-1:0]     rdData_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: cleared on reset, only enabled byte lanes are updated on a write
  always_ff @(posedge sys_clk18 or negedge n_sys_reset18) begin
    if (!n_sys_reset18) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (wrEn_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (!wrBeN_i[b]) begin
          mem_q[wrAddr_i][b*8 +: 8] <= wrData_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/smc_mem_resp_lite18.sv
// smc_mem_resp_lite18
//   Memory-side responder for a static memory controller bus. Decodes the
//   chip-select / read / write strobes into single accesses, inserts a
//   programmable number of read wait states, and keeps an access counter.
//   Optional protocol checker compiled in with macro SMC_RESP_CHECK_EN.
//   Ports:
//     sys_clk18, n_sys_reset18      - clock / async active-low reset
//     smc_n_cs18/oe18/we18          - active-low chip select, read, write strobes
//     smc_n_be18                    - active-low byte enables
//     smc_addr18, smc_wdata18       - word address and write data
//     cfg_rd_ws18                   - read wait states before data valid
//     resp_rdata18, resp_rdata_oe18 - read data and its valid/drive enable
//     resp_n_wait18                 - active-low wait while read latency pending
//     acc_count18                   - completed-access counter (wraps)
//     viol18, viol_code18           - sticky violation flag and first code
module smc_mem_resp_lite18
  import smc_resp_pkg_lite18::*;
#(
  parameter int ADDR_W = SMC_ADDR_W_DEF,
  parameter int DATA_W = SMC_DATA_W_DEF
) (
  input  logic                sys_clk18,
  input  logic                n_sys_reset18,
  input  logic                smc_n_cs18,
  input  logic                smc_n_oe18,
  input  logic                smc_n_we18,
  input  logic [DATA_W/8-1:0] smc_n_be18,
  input  logic [ADDR_W-1:0]   smc_addr18,
  input  logic [DATA_W-1:0]   smc_wdata18,
  input  logic [3:0]          cfg_rd_ws18,
  output logic [DATA_W-1:0]   resp_rdata18,
  output logic                resp_rdata_oe18,
  output logic                resp_n_wait18,
  output logic [15:0]         acc_count18,
  output logic                viol18,
  output logic [1:0]          viol_code18
);

  smcState_e             state_q, state_d;
  logic [3:0]            waitCnt_q, waitCnt_d;
  logic [15:0]           accCount_q, accCount_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   beN_q, beN_d;
  logic                  rdataOe_q;
  logic                  nWait_q;
  logic                  viol_q, viol_d;
  logic [1:0]            violCode_q, violCode_d;
  logic                  memWrEn;
  logic [DATA_W-1:0]     memRdata;

  // The pending write is committed on the edge that sees we (or cs) released,
  // using the data captured during the last cycle we was low.
  assign memWrEn = (state_q == ST_WR) && (smc_n_cs18 || smc_n_we18);

  smc_resp_mem_lite18 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .sys_clk18     (sys_clk18),
    .n_sys_reset18 (n_sys_reset18),
    .wrEn_i        (memWrEn),
    .wrAddr_i      (addr_q),
    .wrData_i      (wdata_q),
    .wrBeN_i       (beN_q),
    .rdAddr_i      (smc_addr18),
    .rdData_o      (memRdata)
  );

  // Next-state decode for the access FSM, counter and optional checker
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    accCount_d = accCount_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    beN_d      = beN_q;

    case (state_q)
      ST_IDLE: begin
        if (!smc_n_cs18) state_d = ST_ADDR;
      end

      // Write wins when both strobes are low
      ST_ADDR: begin
        if (smc_n_cs18) begin
          state_d = ST_IDLE;
        end else if (!smc_n_we18) begin
          state_d = ST_WR;
          addr_d  = smc_addr18;
          wdata_d = smc_wdata18;
          beN_d   = smc_n_be18;
        end else if (!smc_n_oe18) begin
          addr_d = smc_addr18;
          if (cfg_rd_ws18 == 4'd0) begin
            state_d    = ST_RD_DATA;
            accCount_d = accCount_q + 16'd1;
          end else begin
            state_d   = ST_RD_WAIT;
            waitCnt_d = cfg_rd_ws18 - 4'd1;
          end
        end
      end

      // Releasing a strobe here aborts the read without counting it
      ST_RD_WAIT: begin
        if (smc_n_cs18) begin
          state_d = ST_IDLE;
        end else if (smc_n_oe18) begin
          state_d = ST_ADDR;
        end else if (waitCnt_q == 4'd0) begin
          state_d    = ST_RD_DATA;
          accCount_d = accCount_q + 16'd1;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end

      // A new address while oe stays low starts a fresh, counted read
      ST_RD_DATA: begin
        if (smc_n_cs18) begin
          state_d = ST_IDLE;
        end else if (smc_n_oe18) begin
          state_d = ST_ADDR;
        end else if (smc_addr18 != addr_q) begin
          addr_d = smc_addr18;
          if (cfg_rd_ws18 == 4'd0) begin
            accCount_d = accCount_q + 16'd1;
          end else begin
            state_d   = ST_RD_WAIT;
            waitCnt_d = cfg_rd_ws18 - 4'd1;
          end
        end
      end

      ST_WR: begin
        if (smc_n_cs18 || smc_n_we18) begin
          accCount_d = accCount_q + 16'd1;
          state_d    = smc_n_cs18 ? ST_IDLE : ST_ADDR;
        end else begin
          addr_d  = smc_addr18;
          wdata_d = smc_wdata18;
          beN_d   = smc_n_be18;
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef SMC_RESP_CHECK_EN
    // Only the first violation is latched; it holds until reset
    viol_d     = viol_q;
    violCode_d = violCode_q;
    if (!viol_q) begin
      if (!smc_n_cs18 && !smc_n_oe18 && !smc_n_we18) begin
        viol_d     = 1'b1;
        violCode_d = VIOL_RW_BOTH;
      end else if ((state_q == ST_RD_WAIT) && smc_n_oe18) begin
        viol_d     = 1'b1;
        violCode_d = VIOL_RD_ABORT;
      end else if ((state_q == ST_WR) && !smc_n_cs18 && !smc_n_we18 &&
                   (smc_addr18 != addr_q)) begin
        viol_d     = 1'b1;
        violCode_d = VIOL_WR_ADDR;
      end
    end
`else
    viol_d     = 1'b0;
    violCode_d = VIOL_NONE;
`endif
  end

  // State and registered outputs; output flags follow the next state so they
  // are valid in the same cycle the FSM occupies that state
  always_ff @(posedge sys_clk18 or negedge n_sys_reset18) begin
    if (!n_sys_reset18) begin
      state_q    <= ST_IDLE;
      waitCnt_q  <= 4'd0;
      accCount_q <= 16'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      beN_q      <= '1;
      rdataOe_q  <= 1'b0;
      nWait_q    <= 1'b1;
      viol_q     <= 1'b0;
      violCode_q <= VIOL_NONE;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      accCount_q <= accCount_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      beN_q      <= beN_d;
      rdataOe_q  <= (state_d == ST_RD_DATA);
      nWait_q    <= (state_d != ST_RD_WAIT);
      viol_q     <= viol_d;
      violCode_q <= violCode_d;
    end
  end

  assign resp_rdata18    = rdataOe_q ? memRdata : '0;
  assign resp_rdata_oe18 = rdataOe_q;
  assign resp_n_wait18   = nWait_q;
  assign acc_count18     = accCount_q;
  assign viol18          = viol_q;
  assign viol_code18     = violCode_q;

endmodule

// File: tb/tb_smc_mem_resp_lite18.sv
// tb_smc_mem_resp_lite18
//   Directed bench for smc_mem_resp_lite18 with hand-computed expectations.
//   Inputs change and outputs are checked on the falling clock edge.
module tb_smc_mem_resp_lite18;

`ifdef SMC_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        sys_clk18;
  logic        n_sys_reset18;
  logic        smc_n_cs18;
  logic        smc_n_oe18;
  logic        smc_n_we18;
  logic [3:0]  smc_n_be18;
  logic [3:0]  smc_addr18;
  logic [31:0] smc_wdata18;
  logic [3:0]  cfg_rd_ws18;
  logic [31:0] resp_rdata18;
  logic        resp_rdata_oe18;
  logic        resp_n_wait18;
  logic [15:0] acc_count18;
  logic        viol18;
  logic [1:0]  viol_code18;

  int vectors;
  int miscompares;

  smc_mem_resp_lite18 dut (
    .sys_clk18       (sys_clk18),
    .n_sys_reset18   (n_sys_reset18),
    .smc_n_cs18      (smc_n_cs18),
    .smc_n_oe18      (smc_n_oe18),
    .smc_n_we18      (smc_n_we18),
    .smc_n_be18      (smc_n_be18),
    .smc_addr18      (smc_addr18),
    .smc_wdata18     (smc_wdata18),
    .cfg_rd_ws18     (cfg_rd_ws18),
    .resp_rdata18    (resp_rdata18),
    .resp_rdata_oe18 (resp_rdata_oe18),
    .resp_n_wait18   (resp_n_wait18),
    .acc_count18     (acc_count18),
    .viol18          (viol18),
    .viol_code18     (viol_code18)
  );

  initial sys_clk18 = 1'b0;
  always #5 sys_clk18 = ~sys_clk18;

  // Drive one bus cycle and move to the next falling edge
  task automatic applyStimulus(input logic cs, input logic oe, input logic we,
                               input logic [3:0] be, input logic [3:0] addr,
                               input logic [31:0] wd);
    smc_n_cs18  = cs;
    smc_n_oe18  = oe;
    smc_n_we18  = we;
    smc_n_be18  = be;
    smc_addr18  = addr;
    smc_wdata18 = wd;
    @(negedge sys_clk18);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_oe"},    {31'd0, resp_rdata_oe18}, 32'd0);
    checkOutput({tag, "_nwait"}, {31'd0, resp_n_wait18},   32'd1);
    checkOutput({tag, "_acc"},   {16'd0, acc_count18},     32'd0);
    checkOutput({tag, "_viol"},  {31'd0, viol18},          32'd0);
    checkOutput({tag, "_code"},  {30'd0, viol_code18},     32'd0);
    checkOutput({tag, "_rdata"}, resp_rdata18,             32'd0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    n_sys_reset18 = 1'b0;
    cfg_rd_ws18   = 4'd0;
    smc_n_cs18    = 1'b1;
    smc_n_oe18    = 1'b1;
    smc_n_we18    = 1'b1;
    smc_n_be18    = 4'hF;
    smc_addr18    = 4'd0;
    smc_wdata18   = 32'd0;
    repeat (2) @(negedge sys_clk18);
    $display("[TB] reset state");
    checkResetValues("rst");
    n_sys_reset18 = 1'b1;

    // Write 0xA5A51234 to addr 3, then read with two wait states
    $display("[TB] write then waited read");
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 4'd3, 32'h0);          // ADDR
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'd3, 32'hA5A5_1234);  // WR
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 4'd3, 32'h0);          // commit
    checkOutput("wr1_acc", {16'd0, acc_count18}, 32'd1);
    cfg_rd_ws18 = 4'd2;
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'd3, 32'h0);
    checkOutput("rd_wait1", {31'd0, resp_n_wait18}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'd3, 32'h0);
    checkOutput("rd_wait2", {31'd0, resp_n_wait18}, 32'd0);
    checkOutput("rd_wait2_oe", {31'd0, resp_rdata_oe18}, 32'd0);
    checkOutput("rd_wait2_rdata", resp_rdata18, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'd3, 32'h0);
    checkOutput("rd_done_nwait", {31'd0, resp_n_wait18}, 32'd1);
    checkOutput("rd_done_oe", {31'd0, resp_rdata_oe18}, 32'd1);
    checkOutput("rd_done_rdata", resp_rdata18, 32'hA5A5_1234);
    checkOutput("rd_done_acc", {16'd0, acc_count18}, 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 4'd3, 32'h0);          // back to ADDR
    checkOutput("rd_rel_rdata", resp_rdata18, 32'd0);
    checkOutput("rd_rel_oe", {31'd0, resp_rdata_oe18}, 32'd0);

    // Partial byte write over reset-zero data, zero-wait read
    $display("[TB] byte-lane write");
    cfg_rd_ws18 = 4'd0;
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1010, 4'd5, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 4'd5, 32'h0);
    checkOutput("be_wr_acc", {16'd0, acc_count18}, 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 4'd5, 32'h0);
    checkOutput("be_rd_rdata", resp_rdata18, 32'h00FF_00FF);
    checkOutput("be_rd_acc", {16'd0, acc_count18}, 32'd4);
    // Address change with oe held low is a new counted access
    applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 4'd3, 32'h0);
    checkOutput("chg_rd_rdata", resp_rdata18, 32'hA5A5_1234);
    checkOutput("chg_rd_acc", {16'd0, acc_count18}, 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 4'd3, 32'h0);

    // Read aborted after one of three wait cycles
    $display("[TB] aborted read");
    cfg_rd_ws18 = 4'd3;
    applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 4'd3, 32'h0);
    checkOutput("abort_wait", {31'd0, resp_n_wait18}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 4'd3, 32'h0);
    checkOutput("abort_acc", {16'd0, acc_count18}, 32'd5);
    checkOutput("abort_nwait", {31'd0, resp_n_wait18}, 32'd1);
    checkOutput("abort_viol", {31'd0, viol18}, {31'd0, CHK});
    checkOutput("abort_code", {30'd0, viol_code18}, CHK ? 32'd2 : 32'd0);

    // Fresh start so the first-violation latch is clear
    n_sys_reset18 = 1'b0;
    @(negedge sys_clk18);
    checkResetValues("rst2");
    n_sys_reset18 = 1'b1;
    cfg_rd_ws18   = 4'd0;

    // oe and we low together: write wins; later WR address change keeps code 1
    $display("[TB] strobe collision");
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 4'd7, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'd7, 32'h1234_5678);
    checkOutput("both_viol", {31'd0, viol18}, {31'd0, CHK});
    checkOutput("both_code", {30'd0, viol_code18}, CHK ? 32'd1 : 32'd0);
    checkOutput("both_oe", {31'd0, resp_rdata_oe18}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'd8, 32'h1234_5678);
    checkOutput("wraddr_code", {30'd0, viol_code18}, CHK ? 32'd1 : 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 4'd8, 32'h0);
    checkOutput("coll_wr_acc", {16'd0, acc_count18}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'd8, 32'h0);
    checkOutput("coll_rd8", resp_rdata18, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'd7, 32'h0);
    checkOutput("coll_rd7", resp_rdata18, 32'h0);
    checkOutput("coll_acc", {16'd0, acc_count18}, 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, 4'd7, 32'h0);          // IDLE

    // Reset in the middle of a write discards it
    $display("[TB] reset mid-write");
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 4'd9, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'd9, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'd9, 32'hDEAD_BEEF);
    #2 n_sys_reset18 = 1'b0;
    #1 checkResetValues("rst_wr");
    smc_n_we18 = 1'b1;
    @(negedge sys_clk18);
    n_sys_reset18 = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'd9, 32'h0);          // IDLE -> ADDR
    checkOutput("post_rst_idle", {31'd0, resp_rdata_oe18}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'd9, 32'h0);
    checkOutput("post_rst_oe", {31'd0, resp_rdata_oe18}, 32'd1);
    checkOutput("post_rst_rdata", resp_rdata18, 32'd0);
    checkOutput("post_rst_acc", {16'd0, acc_count18}, 32'd1);

    // Counter wrap: alternate address each cycle, one access per cycle
    $display("[TB] counter wrap");
    for (int i = 0; i < 65534; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, (i % 2 == 0) ? 4'd10 : 4'd9, 32'h0);
    end
    checkOutput("acc_max", {16'd0, acc_count18}, 32'hFFFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'd10, 32'h0);
    checkOutput("acc_wrap", {16'd0, acc_count18}, 32'h0);
    checkOutput("acc_wrap_oe", {31'd0, resp_rdata_oe18}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, 4'd0, 32'h0);
    checkOutput("final_idle_oe", {31'd0, resp_rdata_oe18}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
